// File: rtl/pmem_scheduler_pkg.sv
// Shared types and constants for the physical-memory line scheduler.
//   pmem_sched_state_e : grant state of the scheduler (one owner at a time)
//   CLINE_W            : cacheline width in bits
//   CLINE_OFFSET_W     : byte-offset bits inside a line (cleared on the bus)
//   line_align()       : forces a byte address onto its line boundary
package pmem_scheduler_pkg;

  localparam int CLINE_W        = 256;
  localparam int CLINE_OFFSET_W = 5;
  localparam int ADDR_W         = 32;
  localparam int AGE_W          = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INST    = 3'd1,
    DATA_RD = 3'd2,
    DATA_WR = 3'd3,
    PF      = 3'd4
  } pmem_sched_state_e;

  function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] i_addr);
    return {i_addr[ADDR_W-1:CLINE_OFFSET_W], {CLINE_OFFSET_W{1'b0}}};
  endfunction

endpackage

// File: rtl/pmem_scheduler_if.sv
// Bundle of every requester and cacheline-adaptor signal around the scheduler.
//   slave  : the scheduler's view (requests/pmem_rdata/pmem_resp in,
//            per-requester rdata/resp and pmem command out)
//   master : the surrounding system's view (caches, prefetcher, adaptor)
interface pmem_scheduler_if #(
  parameter int LINE_W = pmem_scheduler_pkg::CLINE_W
);

  // icache
  logic [31:0]       inst_cline_addr;
  logic              inst_cline_read;
  logic [LINE_W-1:0] inst_cline_rdata;
  logic              inst_cline_resp;
  // dcache
  logic [31:0]       data_cline_addr;
  logic              data_cline_read;
  logic              data_cline_write;
  logic [LINE_W-1:0] data_cline_wdata;
  logic [LINE_W-1:0] data_cline_rdata;
  logic              data_cline_resp;
  // next-line prefetcher
  logic [31:0]       pf_cline_addr;
  logic              pf_cline_read;
  logic [LINE_W-1:0] pf_cline_rdata;
  logic              pf_cline_resp;
  // cacheline adaptor
  logic [31:0]       pmem_address;
  logic [LINE_W-1:0] pmem_rdata;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_read;
  logic              pmem_write;
  logic              pmem_resp;

  modport slave (
    input  inst_cline_addr, inst_cline_read,
    output inst_cline_rdata, inst_cline_resp,
    input  data_cline_addr, data_cline_read, data_cline_write, data_cline_wdata,
    output data_cline_rdata, data_cline_resp,
    input  pf_cline_addr, pf_cline_read,
    output pf_cline_rdata, pf_cline_resp,
    output pmem_address, pmem_wdata, pmem_read, pmem_write,
    input  pmem_rdata, pmem_resp
  );

  modport master (
    output inst_cline_addr, inst_cline_read,
    input  inst_cline_rdata, inst_cline_resp,
    output data_cline_addr, data_cline_read, data_cline_write, data_cline_wdata,
    input  data_cline_rdata, data_cline_resp,
    output pf_cline_addr, pf_cline_read,
    input  pf_cline_rdata, pf_cline_resp,
    input  pmem_address, pmem_wdata, pmem_read, pmem_write,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/pmem_scheduler_sat_counter.sv
// Saturating up-counter used for instruction-fetch aging.
//   clk, rst : clock, asynchronous active-high reset
//   i_inc    : count up by one unless already at LIMIT
//   i_clr    : return to zero (dominates i_inc)
//   o_count  : current count
module pmem_scheduler_sat_counter #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(LIMIT);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count < MAX)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pmem_scheduler.sv
// Grants the single cacheline adaptor to one of icache, dcache or the
// next-line prefetcher, one 256-bit burst at a time.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : requester and adaptor signals (pmem_scheduler_if.slave)
// Priority is data > instruction > prefetch, except that after AGE_LIMIT
// consecutive data grants with an instruction fetch waiting, the fetch wins.
// Every burst returns through IDLE, so the adaptor always sees its command
// drop for at least one cycle and the finished requester can deassert
// before the next arbitration.
module pmem_scheduler
  import pmem_scheduler_pkg::*;
#(
  parameter int AGE_LIMIT = 8,
  parameter int LINE_W    = CLINE_W
) (
  input  logic             clk,
  input  logic             rst,
  pmem_scheduler_if.slave  bus
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  pmem_sched_state_e r_state;
  pmem_sched_state_e w_next;
  logic [31:0]       r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [31:0]       w_grant_addr;
  logic [AGE_W-1:0]  w_age_cnt;
  logic              w_grant;
  logic              w_age_inc;
  logic              w_age_clr;

  // Next-state and aging control. Requests are only looked at in IDLE.
  always_comb begin
    w_next    = r_state;
    w_age_inc = 1'b0;
    w_age_clr = 1'b0;
    unique case (r_state)
      IDLE: begin
        if ((w_age_cnt == AGE_MAX) && bus.inst_cline_read) w_next = INST;
        else if (bus.data_cline_write)                     w_next = DATA_WR;
        else if (bus.data_cline_read)                      w_next = DATA_RD;
        else if (bus.inst_cline_read)                      w_next = INST;
        else if (bus.pf_cline_read)                        w_next = PF;
        else                                               w_next = IDLE;
        // The age only measures how long the current fetch has been starved.
        w_age_clr = !bus.inst_cline_read || (w_next == INST);
        w_age_inc = bus.inst_cline_read && ((w_next == DATA_RD) || (w_next == DATA_WR));
      end
      default: begin
        if (bus.pmem_resp) w_next = IDLE;
      end
    endcase
  end

  assign w_grant = (r_state == IDLE) && (w_next != IDLE);

  always_comb begin
    w_grant_addr = bus.pf_cline_addr;
    case (w_next)
      INST:             w_grant_addr = bus.inst_cline_addr;
      DATA_RD, DATA_WR: w_grant_addr = bus.data_cline_addr;
      default:          w_grant_addr = bus.pf_cline_addr;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Address and write line are captured once at grant and held for the burst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant) begin
      r_addr <= line_align(w_grant_addr);
      if (w_next == DATA_WR) r_wdata <= bus.data_cline_wdata;
    end
  end

  pmem_scheduler_sat_counter #(
    .WIDTH (AGE_W),
    .LIMIT (AGE_LIMIT)
  ) u_age (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_age_inc),
    .i_clr   (w_age_clr),
    .o_count (w_age_cnt)
  );

  // Commands decode straight from the state register so reset drops them at once.
  assign bus.pmem_address = r_addr;
  assign bus.pmem_wdata   = r_wdata;
  assign bus.pmem_read    = (r_state == INST) || (r_state == DATA_RD) || (r_state == PF);
  assign bus.pmem_write   = (r_state == DATA_WR);

  assign bus.inst_cline_resp = bus.pmem_resp && (r_state == INST);
  assign bus.data_cline_resp = bus.pmem_resp && ((r_state == DATA_RD) || (r_state == DATA_WR));
  assign bus.pf_cline_resp   = bus.pmem_resp && (r_state == PF);

  assign bus.inst_cline_rdata = bus.pmem_rdata;
  assign bus.data_cline_rdata = bus.pmem_rdata;
  assign bus.pf_cline_rdata   = bus.pmem_rdata;

endmodule

// File: tb/tb_pmem_scheduler.sv
// Bench for pmem_scheduler: directed scenarios with literal expectations,
// then randomized requesters and a randomized adaptor, all compared every
// cycle against an owner-based model of the arbitration rules.
module tb_pmem_scheduler;

  localparam int LW  = 256;
  localparam int AGE = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pmem_scheduler_if #(.LINE_W(LW)) bus();

  pmem_scheduler #(.AGE_LIMIT(AGE), .LINE_W(LW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Model: who owns the adaptor (0 none, 1 inst, 2 data read, 3 data write, 4 pf)
  int              m_owner;
  int              m_age;
  logic [31:0]     m_addr;
  logic [LW-1:0]   m_wdata;
  int              grant_log[$];

  bit              auto_mem;
  logic            seen_inst, seen_data, seen_pf;
  logic [LW-1:0]   line_b;
  logic [LW-1:0]   line_a5;
  int              k;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int i = 0; i < LW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFE0;
  endfunction

  task automatic model_reset();
    m_owner = 0;
    m_age   = 0;
    m_addr  = '0;
    m_wdata = '0;
  endtask

  // Arbitration rules applied at a clock edge, using the requests seen then.
  task automatic model_update();
    int g;
    g = 0;
    if (rst) begin
      model_reset();
    end else if (m_owner == 0) begin
      if (!bus.inst_cline_read) m_age = 0;
      if (m_age == AGE && bus.inst_cline_read) g = 1;
      else if (bus.data_cline_write)           g = 3;
      else if (bus.data_cline_read)            g = 2;
      else if (bus.inst_cline_read)            g = 1;
      else if (bus.pf_cline_read)              g = 4;
      if (g == 1) m_age = 0;
      else if ((g == 2 || g == 3) && bus.inst_cline_read && m_age < AGE) m_age++;
      if (g == 1) m_addr = align(bus.inst_cline_addr);
      if (g == 2 || g == 3) m_addr = align(bus.data_cline_addr);
      if (g == 4) m_addr = align(bus.pf_cline_addr);
      if (g == 3) m_wdata = bus.data_cline_wdata;
      if (g != 0) grant_log.push_back(g);
      m_owner = g;
    end else if (bus.pmem_resp) begin
      m_owner = 0;
    end
  endtask

  task automatic compare();
    chk("pmem_read", LW'(bus.pmem_read), LW'(m_owner == 1 || m_owner == 2 || m_owner == 4));
    chk("pmem_write", LW'(bus.pmem_write), LW'(m_owner == 3));
    if (m_owner != 0) chk("pmem_address", LW'(bus.pmem_address), LW'(m_addr));
    chk("pmem_wdata", bus.pmem_wdata, m_wdata);
    chk("inst_resp", LW'(bus.inst_cline_resp), LW'(m_owner == 1 && bus.pmem_resp));
    chk("data_resp", LW'(bus.data_cline_resp), LW'((m_owner == 2 || m_owner == 3) && bus.pmem_resp));
    chk("pf_resp", LW'(bus.pf_cline_resp), LW'(m_owner == 4 && bus.pmem_resp));
    if (bus.inst_cline_resp) chk("inst_rdata", bus.inst_cline_rdata, bus.pmem_rdata);
    if (bus.data_cline_resp) chk("data_rdata", bus.data_cline_rdata, bus.pmem_rdata);
    if (bus.pf_cline_resp)   chk("pf_rdata", bus.pf_cline_rdata, bus.pmem_rdata);
    chk("age_cnt", LW'(dut.w_age_cnt), LW'(m_age));
  endtask

  // One clock: inputs are already applied (negedge); check, then advance.
  task automatic step();
    if (auto_mem) begin
      bus.pmem_rdata = rand_line();
      bus.pmem_resp  = (bus.pmem_read || bus.pmem_write) && ($urandom_range(0, 2) == 0);
    end
    #1;
    compare();
    seen_inst = bus.inst_cline_resp;
    seen_data = bus.data_cline_resp;
    seen_pf   = bus.pf_cline_resp;
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  initial begin
    bus.inst_cline_addr  = '0;
    bus.inst_cline_read  = 1'b0;
    bus.data_cline_addr  = '0;
    bus.data_cline_read  = 1'b0;
    bus.data_cline_write = 1'b0;
    bus.data_cline_wdata = '0;
    bus.pf_cline_addr    = '0;
    bus.pf_cline_read    = 1'b0;
    bus.pmem_rdata       = '0;
    bus.pmem_resp        = 1'b0;
    auto_mem = 1'b0;
    rst = 1'b1;
    model_reset();
    line_b  = {8{32'h1234_5678}};
    line_a5 = {32{8'hA5}};

    // Reset state
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    step();
    chk("rst_read", LW'(bus.pmem_read), LW'(0));
    chk("rst_write", LW'(bus.pmem_write), LW'(0));
    chk("rst_addr", LW'(bus.pmem_address), LW'(0));
    chk("rst_age", LW'(dut.w_age_cnt), LW'(0));

    // Single instruction fetch
    bus.inst_cline_addr = 32'h0000_1044;
    bus.inst_cline_read = 1'b1;
    step();
    chk("inst_read_n1", LW'(bus.pmem_read), LW'(1));
    chk("inst_addr_n1", LW'(bus.pmem_address), LW'(32'h0000_1040));
    step();
    bus.pmem_rdata = line_b;
    bus.pmem_resp  = 1'b1;
    #1;
    chk("inst_resp_pulse", LW'(bus.inst_cline_resp), LW'(1));
    chk("inst_rdata_lit", bus.inst_cline_rdata, line_b);
    chk("inst_other_resp", LW'(bus.data_cline_resp | bus.pf_cline_resp), LW'(0));
    step();
    bus.pmem_resp = 1'b0;
    bus.inst_cline_read = 1'b0;
    chk("inst_gap_read", LW'(bus.pmem_read), LW'(0));
    step();

    // Three simultaneous requests
    grant_log.delete();
    auto_mem = 1'b1;
    bus.data_cline_addr = 32'h0000_2000;
    bus.inst_cline_addr = 32'h0000_3000;
    bus.pf_cline_addr   = 32'h0000_4000;
    bus.data_cline_read = 1'b1;
    bus.inst_cline_read = 1'b1;
    bus.pf_cline_read   = 1'b1;
    for (int c = 0; c < 80 && (bus.inst_cline_read || bus.data_cline_read || bus.pf_cline_read); c++) begin
      step();
      if (seen_inst) bus.inst_cline_read = 1'b0;
      if (seen_data) bus.data_cline_read = 1'b0;
      if (seen_pf)   bus.pf_cline_read   = 1'b0;
    end
    chk("tri_done", LW'(bus.inst_cline_read | bus.data_cline_read | bus.pf_cline_read), LW'(0));
    chk("tri_count", LW'(grant_log.size()), LW'(3));
    if (grant_log.size() == 3) begin
      chk("tri_first", LW'(grant_log[0]), LW'(2));
      chk("tri_second", LW'(grant_log[1]), LW'(1));
      chk("tri_third", LW'(grant_log[2]), LW'(4));
    end

    // Aging: dcache keeps requesting while a fetch waits
    grant_log.delete();
    bus.data_cline_addr = 32'h0001_0000;
    bus.data_cline_read = 1'b1;
    bus.inst_cline_addr = 32'h0002_0004;
    bus.inst_cline_read = 1'b1;
    for (int c = 0; c < 400 && bus.inst_cline_read; c++) begin
      step();
      if (seen_data) bus.data_cline_addr = bus.data_cline_addr + 32'h20;
      if (seen_inst) bus.inst_cline_read = 1'b0;
    end
    chk("age_inst_done", LW'(bus.inst_cline_read), LW'(0));
    chk("age_after", LW'(dut.w_age_cnt), LW'(0));
    chk("age_grants", LW'(grant_log.size() >= 9), LW'(1));
    if (grant_log.size() >= 9) begin
      for (int i = 0; i < 8; i++) chk("age_data_grant", LW'(grant_log[i]), LW'(2));
      chk("age_ninth_inst", LW'(grant_log[8]), LW'(1));
    end
    for (int c = 0; c < 80 && bus.data_cline_read; c++) begin
      step();
      if (seen_data) bus.data_cline_read = 1'b0;
    end
    chk("age_data_done", LW'(bus.data_cline_read), LW'(0));
    auto_mem = 1'b0;
    bus.pmem_resp = 1'b0;
    step();

    // Read and write together: write wins
    bus.data_cline_addr  = 32'h3000_0020;
    bus.data_cline_wdata = line_a5;
    bus.data_cline_read  = 1'b1;
    bus.data_cline_write = 1'b1;
    step();
    chk("rw_write", LW'(bus.pmem_write), LW'(1));
    chk("rw_read", LW'(bus.pmem_read), LW'(0));
    chk("rw_wdata", bus.pmem_wdata, line_a5);
    chk("rw_addr", LW'(bus.pmem_address), LW'(32'h3000_0020));
    step();
    bus.pmem_resp = 1'b1;
    step();
    bus.pmem_resp = 1'b0;
    bus.data_cline_read  = 1'b0;
    bus.data_cline_write = 1'b0;
    step();

    // Prefetch in flight when the fetch arrives
    bus.pf_cline_addr = 32'h4000_0004;
    bus.pf_cline_read = 1'b1;
    step();
    chk("pf_read", LW'(bus.pmem_read), LW'(1));
    chk("pf_addr", LW'(bus.pmem_address), LW'(32'h4000_0000));
    bus.inst_cline_addr = 32'h5000_0010;
    bus.inst_cline_read = 1'b1;
    step();
    step();
    chk("pf_no_inst_resp", LW'(bus.inst_cline_resp), LW'(0));
    bus.pmem_resp = 1'b1;
    #1;
    chk("pf_resp", LW'(bus.pf_cline_resp), LW'(1));
    chk("pf_inst_quiet", LW'(bus.inst_cline_resp), LW'(0));
    step();
    bus.pmem_resp = 1'b0;
    bus.pf_cline_read = 1'b0;
    chk("pf_gap_read", LW'(bus.pmem_read), LW'(0));
    step();
    chk("pf_then_inst_read", LW'(bus.pmem_read), LW'(1));
    chk("pf_then_inst_addr", LW'(bus.pmem_address), LW'(32'h5000_0000));
    bus.pmem_resp = 1'b1;
    #1;
    chk("pf_then_inst_resp", LW'(bus.inst_cline_resp), LW'(1));
    step();
    bus.pmem_resp = 1'b0;
    bus.inst_cline_read = 1'b0;
    step();

    // Reset in the middle of a write burst
    bus.data_cline_addr  = 32'h6000_0000;
    bus.data_cline_wdata = rand_line();
    bus.data_cline_write = 1'b1;
    step();
    chk("mid_rst_write_before", LW'(bus.pmem_write), LW'(1));
    rst = 1'b1;
    model_reset();
    #1;
    chk("mid_rst_write_drop", LW'(bus.pmem_write), LW'(0));
    chk("mid_rst_read_drop", LW'(bus.pmem_read), LW'(0));
    bus.data_cline_write = 1'b0;
    step();
    rst = 1'b0;
    bus.pmem_resp = 1'b1;
    step();
    chk("mid_rst_no_resp", LW'(bus.data_cline_resp | bus.inst_cline_resp | bus.pf_cline_resp), LW'(0));
    bus.pmem_resp = 1'b0;
    step();

    // Randomized traffic
    auto_mem = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      if (seen_inst || !bus.inst_cline_read) begin
        bus.inst_cline_read = ($urandom_range(0, 2) == 0);
        bus.inst_cline_addr = $urandom;
      end
      if (seen_data || (!bus.data_cline_read && !bus.data_cline_write)) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.data_cline_read  = 1'b0;
          bus.data_cline_write = 1'b0;
        end else begin
          k = $urandom_range(0, 2);
          bus.data_cline_read  = (k != 1);
          bus.data_cline_write = (k != 0);
          bus.data_cline_addr  = $urandom;
          bus.data_cline_wdata = rand_line();
        end
      end
      if (seen_pf || !bus.pf_cline_read) begin
        bus.pf_cline_read = ($urandom_range(0, 2) == 0);
        bus.pf_cline_addr = $urandom;
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
